vpu_dst_port_packer: RTL and testbench
======================================

// Module: vpu_dst_port_packer
// PURPOSE
//  Destination-side write port of the VPU; it is the write-back stage after the vector lanes.
//  Collects half-SRAM-width execution results one beat at a time and packs two beats (lo, hi) into one SRAM word.
//  Writes each word to the destination SRAM through a req/ready handshake, then reports done to VPU_CONTROLLER.
//  It mirrors the source port, which splits each SRAM word into two execution-width beats.
// PARAMETERS
//  SRAM_DATA_WIDTH   256  width of one SRAM word / write data
//  EXEC_DATA_WIDTH   128  width of one lane result beat; must equal SRAM_DATA_WIDTH/2
//  ADDR_WIDTH        16   SRAM word address width
//  WORDS_PER_OP      1    SRAM words written per operation (>=1)
// PORTS
//  clk            in   1                clock
//  rst_n          in   1                synchronous, active-low reset
//  start_i        in   1                op start pulse from controller; sampled only in IDLE
//  dst_addr_i     in   ADDR_WIDTH       first destination word address; latched with start_i
//  result_valid_i in   1                lane result beat valid
//  result_data_i  in   EXEC_DATA_WIDTH  lane result beat
//  result_ready_o out  1                beat accepted when valid & ready
//  wreq_o         out  1                SRAM write request
//  waddr_o        out  ADDR_WIDTH       SRAM write address
//  wdata_o        out  SRAM_DATA_WIDTH  SRAM write data {hi, lo}
//  wready_i       in   1                SRAM accepts the write when wreq_o & wready_i
//  busy_o         out  1                state != IDLE
//  done_o         out  1                one-cycle pulse; last word of the op has been written
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal registers 0; waddr_o=0, wdata_o=0.
//  FSM states: IDLE -> COLLECT -> WRITE -> (COLLECT | DONE) -> IDLE.
//  IDLE:
//   - start_i=1 latches dst_addr_i into addr_q, clears word_cnt and beat_sel.
//   - Next state COLLECT; result_ready_o=0 while in IDLE.
//  COLLECT:
//   - result_ready_o=1.
//   - Accepted beat with beat_sel=0 -> lo_q, beat_sel becomes 1.
//   - Accepted beat with beat_sel=1 -> hi_q, beat_sel becomes 0, next state WRITE.
//   - No accept -> hold all state.
//  WRITE:
//   - wreq_o=1, waddr_o=addr_q, wdata_o={hi_q, lo_q}; all three stay stable until the handshake.
//   - result_ready_o=0 (no skid buffer).
//   - On wready_i: addr_q+1 with modulo 2^ADDR_WIDTH wrap, word_cnt+1.
//   - Then next state DONE if word_cnt==WORDS_PER_OP-1, else COLLECT.
//  DONE: done_o=1 for exactly this one cycle; next state IDLE.
//  Latency:
//   - The second beat accepted at cycle t gives wreq_o=1 at t+1.
//   - With wready_i=1, the write is accepted at t+1 and done_o=1 at t+2 on the last word.
//  Throughput: max one word per 3 cycles (2 beats + 1 write).
//  Outside WRITE: wreq_o=0; waddr_o/wdata_o hold their last value.
//  start_i while busy_o=1: ignored, with no effect on the address or the counters.
//  start_i in the DONE cycle: ignored; the controller re-issues start_i once busy_o=0.
//  result_valid_i while ready=0: not consumed; the lane holds the beat.
//  wready_i while wreq_o=0: ignored.
//  rst_n=0 mid-op, from any state: IDLE next cycle, partial word dropped, no wreq_o, no done_o.
//  word_cnt width is $clog2(WORDS_PER_OP+1).
//  ADDR_WIDTH wrap is permitted and not flagged.
// TESTING
//  T1: start, addr=0x0010, beats 0xA..A then 0xB..B, wready=1
//      -> one write: addr 0x0010, data {B..B, A..A}; done_o at 2nd beat +2 cycles.
//  T2: WORDS_PER_OP=4, addr=0x0020, 8 beats back-to-back
//      -> writes at 0x20, 0x21, 0x22, 0x23 in order; exactly one done_o after the 4th.
//  T3: wready_i low 5 cycles during WRITE
//      -> wreq/waddr/wdata stable for 6 cycles, result_ready_o=0 throughout, one write only.
//  T4: addr=0xFFFF, WORDS_PER_OP=2
//      -> writes at 0xFFFF then 0x0000.
//  T5: start_i pulsed in COLLECT with addr=0x0500
//      -> ignored; writes keep the original address.
//  T6: rst_n low after the first beat
//      -> IDLE, no wreq_o, no done_o; a new op afterwards packs fresh beats correctly.

Source files
------------

// File: rtl/vpu_dst_port_packer.sv
// VPU destination write port: packs two lane result beats (lo, hi)
// into one SRAM word and writes it through a req/ready handshake.
module vpu_dst_port_packer #(
    parameter int SRAM_DATA_WIDTH = 256,
    parameter int EXEC_DATA_WIDTH = 128,
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_OP    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [ADDR_WIDTH-1:0]      dst_addr_i,
    input  logic                       result_valid_i,
    input  logic [EXEC_DATA_WIDTH-1:0] result_data_i,
    output logic                       result_ready_o,
    output logic                       wreq_o,
    output logic [ADDR_WIDTH-1:0]      waddr_o,
    output logic [SRAM_DATA_WIDTH-1:0] wdata_o,
    input  logic                       wready_i,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int CW = $clog2(WORDS_PER_OP + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_OP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
    logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [EXEC_DATA_WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       sel_q, sel_d;

    logic accept;
    logic wr_fire;

    assign accept  = (state_q == S_COLLECT) && result_valid_i;
    assign wr_fire = (state_q == S_WRITE) && wready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start_i) state_d = S_COLLECT;
            S_COLLECT: if (accept && sel_q) state_d = S_WRITE;
            S_WRITE: begin
                if (wr_fire) begin
                    state_d = (cnt_q == LAST_WORD) ? S_DONE : S_COLLECT;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Write address/data are captured with the hi beat so they stay
    // stable through WRITE and hold their value afterwards.
    always_comb begin
        addr_d  = addr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if ((state_q == S_IDLE) && start_i) begin
            addr_d = dst_addr_i;
            cnt_d  = '0;
            sel_d  = 1'b0;
        end
        if (accept) begin
            if (!sel_q) begin
                lo_d  = result_data_i;
                sel_d = 1'b1;
            end else begin
                waddr_d = addr_q;
                wdata_d = {result_data_i, lo_q};
                sel_d   = 1'b0;
            end
        end
        if (wr_fire) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_comb begin
        result_ready_o = (state_q == S_COLLECT);
        wreq_o         = (state_q == S_WRITE);
        busy_o         = (state_q != S_IDLE);
        done_o         = (state_q == S_DONE);
        waddr_o        = waddr_q;
        wdata_o        = wdata_q;
    end

endmodule

// File: tb/tb_vpu_dst_port_packer.sv
// Bench for vpu_dst_port_packer: one instance with one word per op,
// one with four words per op; inputs are shared, sel picks the one checked.
module tb_vpu_dst_port_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  addr = '0;
    logic         valid = 1'b0;
    logic [127:0] data = '0;
    logic         wready = 1'b0;
    logic         sel = 1'b0;

    always #5 clk = ~clk;

    logic         r1, q1, b1, n1;
    logic [15:0]  a1;
    logic [255:0] d1;
    logic         r4, q4, b4, n4;
    logic [15:0]  a4;
    logic [255:0] d4;

    vpu_dst_port_packer #(.WORDS_PER_OP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .dst_addr_i(addr),
        .result_valid_i(valid), .result_data_i(data),
        .result_ready_o(r1), .wreq_o(q1), .waddr_o(a1), .wdata_o(d1),
        .wready_i(wready), .busy_o(b1), .done_o(n1)
    );

    vpu_dst_port_packer #(.WORDS_PER_OP(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .dst_addr_i(addr),
        .result_valid_i(valid), .result_data_i(data),
        .result_ready_o(r4), .wreq_o(q4), .waddr_o(a4), .wdata_o(d4),
        .wready_i(wready), .busy_o(b4), .done_o(n4)
    );

    logic         rdy, wreq, busy, done;
    logic [15:0]  waddr;
    logic [255:0] wdata;

    always_comb begin
        rdy   = sel ? r4 : r1;
        wreq  = sel ? q4 : q1;
        busy  = sel ? b4 : b1;
        done  = sel ? n4 : n1;
        waddr = sel ? a4 : a1;
        wdata = sel ? d4 : d1;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0]  wa_q[$];
    logic [255:0] wd_q[$];
    int           wc_q[$];
    int done_n = 0, done_cyc = 0, acc_n = 0, acc_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (rdy && valid) begin
            acc_n++;
            acc_cyc = cyc;
        end
        if (wreq && wready) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clr_logs();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_n = 0;
        acc_n = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr_logs();
    endtask

    task automatic start_op(input logic [15:0] a);
        start = 1'b1;
        addr = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [127:0] d);
        int n = 0;
        valid = 1'b1;
        data = d;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("beat_wait", 256'(n < 20), 256'(1));
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 256'(done), 256'(1));
        @(negedge clk);
    endtask

    function automatic logic [127:0] bv(input int k);
        logic [7:0] b;
        b = 8'(k + 1);
        return {16{b}};
    endfunction

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] lo;
        logic [127:0] hi;
        logic [15:0]  eaddr;
        logic [255:0] edata;
    } vec_t;

    vec_t tbl[3];

    initial begin
        tbl[0] = '{16'h0010, {4{32'hAAAAAAAA}}, {4{32'hBBBBBBBB}}, 16'h0010,
                   {{4{32'hBBBBBBBB}}, {4{32'hAAAAAAAA}}}};
        tbl[1] = '{16'h1234, 128'h0123456789ABCDEF_FEDCBA9876543210,
                   128'h00000000_11111111_22222222_33333333, 16'h1234,
                   256'h00000000_11111111_22222222_33333333_0123456789ABCDEF_FEDCBA9876543210};
        tbl[2] = '{16'h0000, 128'h0, {4{32'hFFFFFFFF}}, 16'h0000,
                   {{4{32'hFFFFFFFF}}, {4{32'h00000000}}}};

        // Reset state of both instances, checked while rst_n is low.
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready1", 256'(r1), 256'(0));
        chk("rst_wreq1", 256'(q1), 256'(0));
        chk("rst_waddr1", 256'(a1), 256'(0));
        chk("rst_wdata1", d1, 256'(0));
        chk("rst_busy1", 256'(b1), 256'(0));
        chk("rst_done1", 256'(n1), 256'(0));
        chk("rst_ready4", 256'(r4), 256'(0));
        chk("rst_wreq4", 256'(q4), 256'(0));
        chk("rst_waddr4", 256'(a4), 256'(0));
        chk("rst_wdata4", d4, 256'(0));
        chk("rst_busy4", 256'(b4), 256'(0));
        chk("rst_done4", 256'(n4), 256'(0));

        // Single-word ops from the table.
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            wready = 1'b1;
            start_op(tbl[i].addr);
            beat(tbl[i].lo);
            beat(tbl[i].hi);
            valid = 1'b0;
            wait_done();
            chk("tbl_nwr", 256'(wa_q.size()), 256'(1));
            if (wa_q.size() > 0) begin
                chk("tbl_addr", 256'(wa_q[0]), 256'(tbl[i].eaddr));
                chk("tbl_data", wd_q[0], tbl[i].edata);
                chk("tbl_wr_lat", 256'(wc_q[0] - acc_cyc), 256'(1));
            end
            chk("tbl_done_lat", 256'(done_cyc - acc_cyc), 256'(2));
            chk("tbl_ndone", 256'(done_n), 256'(1));
            chk("tbl_busy", 256'(busy), 256'(0));
            chk("tbl_wreq", 256'(wreq), 256'(0));
            chk("tbl_hold_a", 256'(waddr), 256'(tbl[i].eaddr));
            chk("tbl_hold_d", wdata, tbl[i].edata);
        end

        // Four words, back-to-back beats.
        sel = 1'b1;
        do_reset();
        wready = 1'b1;
        start_op(16'h0020);
        for (int k = 0; k < 8; k++) beat(bv(k));
        valid = 1'b0;
        wait_done();
        chk("t2_nwr", 256'(wa_q.size()), 256'(4));
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            chk("t2_addr", 256'(wa_q[i]), 256'(16'h0020 + 16'(i)));
            chk("t2_data", wd_q[i], {bv(2 * i + 1), bv(2 * i)});
        end
        chk("t2_ndone", 256'(done_n), 256'(1));
        if (wc_q.size() == 4) chk("t2_done_cyc", 256'(done_cyc - wc_q[3]), 256'(1));

        // Write stalled by wready low for five cycles.
        sel = 1'b0;
        do_reset();
        wready = 1'b0;
        start_op(16'h0077);
        beat({4{32'h11112222}});
        beat({4{32'h33334444}});
        for (int i = 0; i < 6; i++) begin
            chk("t3_wreq", 256'(wreq), 256'(1));
            chk("t3_waddr", 256'(waddr), 256'(16'h0077));
            chk("t3_wdata", wdata, {{4{32'h33334444}}, {4{32'h11112222}}});
            chk("t3_ready", 256'(rdy), 256'(0));
            if (i == 5) wready = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
        wait_done();
        chk("t3_nwr", 256'(wa_q.size()), 256'(1));
        chk("t3_nacc", 256'(acc_n), 256'(2));

        // Address wrap at 0xFFFF.
        sel = 1'b1;
        do_reset();
        wready = 1'b1;
        start_op(16'hFFFF);
        for (int k = 0; k < 8; k++) beat(bv(k + 8));
        valid = 1'b0;
        wait_done();
        chk("t4_nwr", 256'(wa_q.size()), 256'(4));
        if (wa_q.size() == 4) begin
            chk("t4_a0", 256'(wa_q[0]), 256'(16'hFFFF));
            chk("t4_a1", 256'(wa_q[1]), 256'(16'h0000));
            chk("t4_a2", 256'(wa_q[2]), 256'(16'h0001));
            chk("t4_a3", 256'(wa_q[3]), 256'(16'h0002));
            chk("t4_d1", wd_q[1], {bv(11), bv(10)});
        end

        // start_i while collecting and in the DONE cycle is ignored.
        sel = 1'b0;
        do_reset();
        wready = 1'b1;
        start_op(16'h0040);
        beat({4{32'h55555555}});
        start = 1'b1;
        addr = 16'h0500;
        beat({4{32'h66666666}});
        start = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("t5_done", 256'(done), 256'(1));
        start = 1'b1;
        addr = 16'h0600;
        @(negedge clk);
        start = 1'b0;
        chk("t5_idle", 256'(busy), 256'(0));
        chk("t5_nwr", 256'(wa_q.size()), 256'(1));
        if (wa_q.size() > 0) chk("t5_addr", 256'(wa_q[0]), 256'(16'h0040));

        // Reset mid-op drops the partial word.
        do_reset();
        wready = 1'b1;
        start_op(16'h0100);
        beat({4{32'h77777777}});
        valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_busy", 256'(busy), 256'(0));
        chk("t6_wreq", 256'(wreq), 256'(0));
        chk("t6_ready", 256'(rdy), 256'(0));
        @(negedge clk);
        @(negedge clk);
        chk("t6_nwr0", 256'(wa_q.size()), 256'(0));
        chk("t6_ndone0", 256'(done_n), 256'(0));
        start_op(16'h0101);
        beat({4{32'h88888888}});
        beat({4{32'h99999999}});
        valid = 1'b0;
        wait_done();
        chk("t6_nwr", 256'(wa_q.size()), 256'(1));
        if (wa_q.size() > 0) begin
            chk("t6_addr", 256'(wa_q[0]), 256'(16'h0101));
            chk("t6_data", wd_q[0], {{4{32'h99999999}}, {4{32'h88888888}}});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
